dice_roller: RTL

Consumes the periodic enable pulse from the rate divider in dice mode (rate 2'b00, about 25 Hz at 50 MHz) and turns it into a die face 1–6. While the player holds roll, the face spins. On release it decelerates through a settle sequence, then holds the final face with a valid/ack handshake toward the game controller. The block sits between the rate divider and the board/turn FSM, and drives the dice HEX display path.

---
 rtl/dice_pkg.sv | 25 ++
 rtl/dice_lfsr.sv | 26 ++
 rtl/dice_roller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller: FSM states, die face limits,
// LFSR taps and the face-advance / feedback helpers.
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPIN   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } dice_state_e;

    localparam logic [2:0] DIE_MIN   = 3'd1;
    localparam logic [2:0] DIE_MAX   = 3'd6;
    // Taps q[7], q[5], q[4], q[3]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [2:0] die_advance(input logic [2:0] face);
        return (face == DIE_MAX) ? DIE_MIN : face + 3'd1;
    endfunction

    function automatic logic lfsr_feedback(input logic [7:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; only the low two bits are consumed
// by the roller, so only those are exported.
module dice_lfsr
    import dice_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clock,
    input  logic       i_reset,
    output logic [1:0] o_low
);

    logic [7:0] r_q;

    // Shift left every clock, feedback into bit 0
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[6:0], lfsr_feedback(r_q)};
        end
    end

    assign o_low = r_q[1:0];

endmodule

// File: rtl/dice_roller.sv
// Dice roller: spins the face on tick edges while roll is held, then settles
// with growing gaps between advances and presents the result with valid/ack.
module dice_roller
    import dice_pkg::*;
#(
    parameter int         SETTLE_STEPS  = 3,
    parameter bit         RANDOM_SETTLE = 1'b1,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_roll,
    input  logic       i_ack,
    output logic [2:0] o_value,
    output logic       o_rolling,
    output logic       o_valid
);

    localparam logic [3:0] SETTLE_BASE = 4'(SETTLE_STEPS);

    dice_state_e r_state;
    dice_state_e w_state_next;
    logic        r_tick_d;
    logic [2:0]  r_value;
    logic [2:0]  w_value_next;
    logic [3:0]  r_k;
    logic [3:0]  w_k_next;
    logic [3:0]  r_gap;
    logic [3:0]  w_gap_next;
    logic [3:0]  r_total;
    logic [3:0]  w_total_next;
    logic [1:0]  w_lfsr_low;
    logic [3:0]  w_extra;
    logic        w_tick_edge;

    dice_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_low   (w_lfsr_low)
    );

    assign w_tick_edge = i_tick & ~r_tick_d;
    assign w_extra     = RANDOM_SETTLE ? {2'b00, w_lfsr_low} : 4'd0;

    // State and datapath registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_tick_d <= 1'b0;
            r_value  <= DIE_MIN;
            r_k      <= 4'd0;
            r_gap    <= 4'd0;
            r_total  <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_tick_d <= i_tick;
            r_value  <= w_value_next;
            r_k      <= w_k_next;
            r_gap    <= w_gap_next;
            r_total  <= w_total_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_next = r_state;
        w_value_next = r_value;
        w_k_next     = r_k;
        w_gap_next   = r_gap;
        w_total_next = r_total;
        case (r_state)
            ST_IDLE: begin
                if (i_roll) begin
                    w_state_next = ST_SPIN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SPIN: begin
                if (w_tick_edge) begin
                    w_value_next = die_advance(r_value);
                end else begin
                    w_value_next = r_value;
                end
                if (!i_roll) begin
                    w_state_next = ST_SETTLE;
                    w_total_next = SETTLE_BASE + w_extra;
                    w_k_next     = 4'd1;
                    w_gap_next   = 4'd0;
                end else begin
                    w_state_next = ST_SPIN;
                end
            end
            ST_SETTLE: begin
                // r_k - 1 advances are done so far; advancing at k == total is the last one
                if (w_tick_edge) begin
                    if (r_gap + 4'd1 == r_k) begin
                        w_value_next = die_advance(r_value);
                        w_gap_next   = 4'd0;
                        w_k_next     = r_k + 4'd1;
                        if (r_k == r_total) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_state_next = ST_SETTLE;
                        end
                    end else begin
                        w_gap_next = r_gap + 4'd1;
                    end
                end else begin
                    w_gap_next = r_gap;
                end
            end
            ST_DONE: begin
                if (i_ack) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_value   = r_value;
    assign o_rolling = (r_state == ST_SPIN) || (r_state == ST_SETTLE);
    assign o_valid   = (r_state == ST_DONE);

endmodule
